// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;
    typedef enum logic [2:0] {SYNC, REQ, WAIT, HOLD, DRAIN} fetch_state_t;

    localparam int PC_INC_DEF = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: captures a fetched word with its PC and holds it
// until decode takes it or it is cleared by a redirect.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [XLEN-1:0]    pc_d,
    input  logic               ready,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    pc
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= INSTR_W'(NOP_INSTR);
            pc    <= '0;
        end else if (clear) begin
            // A kill wins even when decode is ready in the same cycle.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_d;
            pc    <= pc_d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch controller: one outstanding imem request, drives the PC load port
// with either the sequential increment or an execute-stage redirect.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32,
    parameter int PC_INC  = PC_INC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_next,
    output logic               pc_ld,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_target,
    output logic               imem_req_valid,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [XLEN-1:0]    if_pc,
    input  logic               if_ready
);
    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic            ir_load, ir_clear;

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst)                                  fetch_pc <= '0;
        else if (state == REQ && imem_req_ready)  fetch_pc <= pc;
    end

    // A redirect either abandons the fetch (SYNC) or, if a request is
    // already in flight, waits for its response to come back (DRAIN).
    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:  state_nxt = redirect_valid ? SYNC : REQ;
            REQ: begin
                if (redirect_valid)      state_nxt = imem_req_ready ? DRAIN : SYNC;
                else if (imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (redirect_valid)      state_nxt = imem_rsp_valid ? SYNC : DRAIN;
                else if (imem_rsp_valid) state_nxt = HOLD;
            end
            HOLD: begin
                if (redirect_valid) state_nxt = SYNC;
                else if (if_ready)  state_nxt = REQ;
            end
            DRAIN: state_nxt = imem_rsp_valid ? SYNC : DRAIN;
            default: state_nxt = SYNC;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        pc_ld          = 1'b0;
        pc_next        = '0;
        if (!rst) begin
            if (state == REQ) begin
                imem_req_valid = 1'b1;
                imem_req_addr  = pc;
            end
            if (redirect_valid) begin
                pc_ld   = 1'b1;
                pc_next = redirect_target;
            end else if (state == WAIT && imem_rsp_valid) begin
                pc_ld   = 1'b1;
                pc_next = fetch_pc + XLEN'(PC_INC);
            end
        end
    end

    assign ir_load  = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign ir_clear = redirect_valid;

    if_id_reg #(.XLEN(XLEN), .INSTR_W(INSTR_W)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .load    (ir_load),
        .clear   (ir_clear),
        .instr_d (imem_rsp_data),
        .pc_d    (fetch_pc),
        .ready   (if_ready),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run, all
// checked against a transaction-level model of PC, memory and decode stream.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0, pc_next, redirect_target = '0, imem_req_addr;
    logic [31:0] imem_rsp_data = '0, if_instr, if_pc;
    logic        pc_ld, redirect_valid = 1'b0, imem_req_valid, imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0, if_valid, if_ready = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .pc_ld(pc_ld),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready)
    );

    int checks = 0, errors = 0, delivered = 0;
    // model state: program counter, memory, expected decode stream
    logic [31:0] pc_q = '0, exp_pc = '0, live_addr = '0, prev_addr = '0, drv_tgt = '0;
    bit mem_busy = 0, live_killed = 0, prev_hold = 0, prev_redir = 0;
    bit drv_rst = 1, drv_rdy = 1, drv_mrdy = 1, drv_redir = 0;
    int mem_cnt = 0, lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_valid"}, if_valid, 0);
        chk({tag, "_if_instr"}, if_instr, 0);
        chk({tag, "_if_pc"}, if_pc, 0);
        chk({tag, "_pc_ld"}, pc_ld, 0);
        chk({tag, "_pc_next"}, pc_next, 0);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_req_addr"}, imem_req_addr, 0);
    endtask

    // One clock: drive inputs at negedge, observe, run the model, advance it.
    task automatic step();
        logic exp_ld;
        @(negedge clk);
        rst = drv_rst; if_ready = drv_rdy; imem_req_ready = drv_mrdy;
        redirect_valid = drv_redir; redirect_target = drv_tgt; pc = pc_q;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if (mem_busy && !drv_rst) begin
            if (mem_cnt == 0) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(live_addr); mem_busy = 0;
            end else mem_cnt--;
        end
        #1;
        if (drv_rst) begin
            chk("rst_pc_ld", pc_ld, 0);
            mem_busy = 0; exp_pc = pc_q; prev_hold = 0; prev_redir = 0;
        end else begin
            if (prev_redir) chk("if_valid_after_redirect", if_valid, 0);
            if (prev_hold) begin
                chk("req_hold_valid", imem_req_valid, 1);
                chk("req_hold_addr", imem_req_addr, prev_addr);
            end
            exp_ld = drv_redir || (imem_rsp_valid && !live_killed);
            chk("pc_ld", pc_ld, exp_ld);
            if (drv_redir)   chk("pc_next_redirect", pc_next, drv_tgt);
            else if (exp_ld) chk("pc_next_seq", pc_next, live_addr + 32'd4);
            if (if_valid && if_ready && !drv_redir) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, mem_word(exp_pc));
                exp_pc += 32'd4; delivered++;
            end
            if (drv_redir) exp_pc = drv_tgt;
            if (imem_req_valid && imem_req_ready) begin
                chk("one_outstanding", mem_busy, 0);
                mem_busy = 1; mem_cnt = lat; live_addr = imem_req_addr; live_killed = drv_redir;
            end else if (drv_redir && mem_busy) live_killed = 1;
            if (pc_ld) pc_q = pc_next;
            prev_hold  = imem_req_valid && !imem_req_ready && !drv_redir;
            prev_addr  = imem_req_addr;
            prev_redir = drv_redir;
        end
        drv_redir = 0;
    endtask

    initial begin
        bit seen;
        logic [31:0] r;
        // reset state
        step(); step();
        chk_zero("reset");
        drv_rst = 0;
        step();
        chk("sync_req_valid", imem_req_valid, 0);
        // first fetch from 0
        step();
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        step();
        chk("first_pc_ld", pc_ld, 1);
        chk("first_pc_next", pc_next, 32'h4);
        step();
        chk("first_if_valid", if_valid, 1);
        chk("first_if_pc", if_pc, 32'h0);
        chk("first_if_instr", if_instr, 32'h0050_0093);
        step();
        chk("second_req_addr", imem_req_addr, 32'h4);
        step();
        // decode stalls for several cycles in HOLD
        drv_rdy = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_if_valid", if_valid, 1);
            chk("stall_if_pc", if_pc, 32'h4);
            chk("stall_if_instr", if_instr, mem_word(32'h4));
            chk("stall_no_req", imem_req_valid, 0);
            chk("stall_no_pc_ld", pc_ld, 0);
            step();
        end
        drv_rdy = 1;
        step();
        // redirect while waiting on a slow response for addr 8
        lat = 3;
        step();
        chk("wait_req_addr", imem_req_addr, 32'h8);
        lat = 0; drv_redir = 1; drv_tgt = 32'h100;
        step();
        chk("redir_wait_pc_ld", pc_ld, 1);
        chk("redir_wait_pc_next", pc_next, 32'h100);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (imem_req_valid) seen = 1;
            else chk("drain_if_valid", if_valid, 0);
        end
        chk("redir_req_seen", seen, 1);
        chk("redir_req_addr", imem_req_addr, 32'h100);
        // redirect in the same cycle as the response
        drv_redir = 1; drv_tgt = 32'h100;
        step();
        chk("same_cycle_pc_ld", pc_ld, 1);
        chk("same_cycle_pc_next", pc_next, 32'h100);
        step();
        chk("same_cycle_if_valid", if_valid, 0);
        drv_mrdy = 0;
        step();
        chk("refetch_req_valid", imem_req_valid, 1);
        chk("refetch_req_addr", imem_req_addr, 32'h100);
        // redirect to the top of the address space, then wrap
        drv_redir = 1; drv_tgt = 32'hFFFF_FFFC;
        step();
        chk("top_redir_pc_next", pc_next, 32'hFFFF_FFFC);
        drv_mrdy = 1;
        step(); step();
        chk("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc_ld", pc_ld, 1);
        chk("wrap_pc_next", pc_next, 32'h0);
        step();
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        lat = 2;
        step();
        chk("wrap_req_addr", imem_req_addr, 32'h0);
        // reset while waiting on memory
        step();
        drv_rst = 1; step();
        drv_rst = 0; step();
        chk_zero("rst_wait");
        lat = 0;
        step();
        chk("rst_wait_req_addr", imem_req_addr, 32'h0);
        step();
        // reset while holding an instruction
        drv_rdy = 0;
        step();
        chk("pre_rst_hold_valid", if_valid, 1);
        drv_rst = 1; step();
        drv_rst = 0; step();
        chk_zero("rst_hold");
        step();
        chk("rst_hold_req_addr", imem_req_addr, 32'h4);
        // randomized traffic
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            drv_rdy  = ($urandom % 10) < 6;
            drv_mrdy = ($urandom % 10) < 7;
            lat      = $urandom % 4;
            if (($urandom % 100) < 3) begin
                r = $urandom;
                drv_redir = 1; drv_tgt = {r[31:2], 2'b00};
            end
            step();
        end
        chk("random_progress", delivered > 100, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
